mux_arb_n: RTL and testbench
============================

MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 SHALL provide parameter W, default 32: data width per channel in bits.
REQ-002 SHALL provide parameter N, default 4: channel count, 2..8.
REQ-003 SHALL provide parameter SW, default 2: select/pointer width; N <= 2**SW required.
REQ-004 SHALL provide port clk  input  1: single clock, all state on rising edge.
REQ-005 SHALL provide port rst  input  1: asynchronous active-high reset.
REQ-006 SHALL provide port mode  input  1: 0 = fixed select via sel, 1 = round-robin arbitration.
REQ-007 SHALL provide port sel  input  SW: channel index used when mode=0.
REQ-008 SHALL provide port in_valid  input  N: per-channel beat valid.
REQ-009 SHALL provide port in_data  input  N*W: channel i occupies bits [i*W+W-1 : i*W].
REQ-010 SHALL provide port in_ready  output  N: per-channel accept; at most one bit high per cycle.
REQ-011 SHALL provide port out_valid  output  1: registered output beat valid.
REQ-012 SHALL provide port out_data  output  W: registered output data.
REQ-013 SHALL provide port out_ch  output  SW: index of channel that supplied out_data.
REQ-014 SHALL provide port out_ready  input  1: downstream accept.
REQ-015 SHALL provide port xfer_cnt  output  16: count of output handshakes (out_valid && out_ready).

Function
REQ-016 SHALL define load_en = !out_valid || out_ready; output register loads only when load_en.
REQ-017 SHALL drive in_ready[i] = load_en && (i == g), where g is the granted channel; no grant -> in_ready all 0.
REQ-018 SHALL, in mode 0, set g = sel; sel >= N -> no grant.
REQ-019 SHALL, in mode 1, set g = first i with in_valid[i] high, searching ptr, ptr+1, ... modulo N; none valid -> no grant.
REQ-020 SHALL, on input transfer (in_valid[g] && in_ready[g]), load out_data = channel g data, out_ch = g, out_valid = 1 on the next edge: latency 1 cycle.
REQ-021 SHALL, on transfer in mode 1, update ptr to (g+1) mod N, wrapping N-1 -> 0; ptr unchanged otherwise and in mode 0.
REQ-022 SHALL clear out_valid on the edge where out_valid && out_ready and no new input transfer occurs.
REQ-023 SHALL sustain one beat per cycle when out_ready is held high (simultaneous output drain and input load).
REQ-024 SHALL hold out_data/out_ch/out_valid stable while out_valid && !out_ready.
REQ-025 SHALL apply mode/sel changes combinationally to the grant of the current cycle; ptr is not reset by mode change.
REQ-026 SHALL increment xfer_cnt by 1 per output handshake, wrapping 0xFFFF -> 0x0000.

Reset
REQ-027 SHALL, while rst high, force out_valid=0, out_data=0, out_ch=0, ptr=0, xfer_cnt=0, lock=0, independent of clk.
REQ-028 SHALL discard any beat held in the output register when rst asserts mid-operation; no handshake is counted.

Configuration
REQ-029 SHALL, with macro MUX_ARB_N_LOCK_EN defined, add input in_last (N bits) and output out_last (1 bit, registered with out_data, reset 0).
REQ-030 SHALL, with MUX_ARB_N_LOCK_EN and mode 1, set lock on a transfer with in_last[g]=0, holding g fixed until a transfer with in_last[g]=1 clears lock and advances ptr.
REQ-031 SHALL, with MUX_ARB_N_LOCK_EN, ignore lock in mode 0 and clear lock when mode goes to 0.
REQ-032 SHALL, without MUX_ARB_N_LOCK_EN, omit in_last/out_last and arbitrate per beat.

Verification
REQ-033 SHALL cover: mode=0, sel=0..3 in turn, each channel i valid with data 0xA0+i, out_ready=1 -> out_data 0xA0+sel, out_ch=sel, one cycle after handshake.
REQ-034 SHALL cover: mode=1, all four in_valid high continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,... one beat per cycle.
REQ-035 SHALL cover: mode=1, only channels 1 and 3 valid, ptr=2 -> grant 3, then 1, then 3.
REQ-036 SHALL cover: out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_ch stable, in_ready all 0, xfer_cnt unchanged.
REQ-037 SHALL cover: rst asserted asynchronously between edges while out_valid=1 -> out_valid, out_ch, xfer_cnt read 0 immediately; grant restarts at channel 0.
REQ-038 SHALL cover (MUX_ARB_N_LOCK_EN): channel 0 sends 3 beats with in_last=0,0,1 while channel 1 valid -> out_ch 0,0,0 then 1.

Source files
------------

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel to 1 multiplexer / arbiter with one registered output stage.
//   mode = 0 : the channel named by sel is granted (sel >= N grants nothing).
//   mode = 1 : round-robin grant starting the search at the rotating pointer.
// A beat moves from the granted channel into the output register whenever the
// register is empty or being drained this cycle, so a held-high out_ready gives
// one beat per clock.
// Optional feature, enabled by defining MUX_ARB_N_LOCK_EN: adds in_last/out_last.
// In round-robin mode the grant is then locked to one channel from its first beat
// until the beat that carries in_last.
module mux_arb_n #(
  parameter int W  = 32,
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  input  logic            out_ready,
  output logic [15:0]     xfer_cnt
`ifdef MUX_ARB_N_LOCK_EN
  ,
  input  logic [N-1:0]    in_last,
  output logic            out_last
`endif
);

  logic          valid_q, valid_d;
  logic [W-1:0]  data_q,  data_d;
  logic [SW-1:0] ch_q,    ch_d;
  logic [SW-1:0] ptr_q,   ptr_d;
  logic [15:0]   cnt_q,   cnt_d;
`ifdef MUX_ARB_N_LOCK_EN
  logic          lock_q,  lock_d;
  logic          last_q,  last_d;
  logic          grant_last;
`endif

  logic          load_en;
  logic          out_hs;
  logic          in_xfer;
  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic [SW-1:0] ptr_inc;
  logic [W-1:0]  grant_data;
  logic [N-1:0]  rotated;
  logic [SW:0]   sum;

  assign load_en = !valid_q || out_ready;
  assign out_hs  = valid_q && out_ready;

  // Pick the granted channel: fixed select, locked channel, or first valid from ptr.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    grant_vld = 1'b0;
    grant_idx = '0;
    rotated   = '0;
    sum       = '0;
    if (!mode) begin
      if (int'(sel) < N) begin
        grant_vld = 1'b1;
        grant_idx = sel;
      end
    end
`ifdef MUX_ARB_N_LOCK_EN
    else if (lock_q) begin
      grant_vld = 1'b1;
      grant_idx = ptr_q;
    end
`endif
    else begin
      // Rotate so bit 0 is the channel at ptr; the lowest set bit is the winner.
      rotated = N'({in_valid, in_valid} >> ptr_q);
      for (int k = N - 1; k >= 0; k--) begin
        if (rotated[k]) begin
          grant_vld = 1'b1;
          sum       = {1'b0, ptr_q} + (SW+1)'(k);
        end
      end
      if (sum >= (SW+1)'(N)) sum = sum - (SW+1)'(N);
      grant_idx = sum[SW-1:0];
    end
  end

  // Decode the grant into per-channel ready and select the granted beat.
  always_comb begin
    in_ready   = '0;
    grant_data = '0;
`ifdef MUX_ARB_N_LOCK_EN
    grant_last = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SW'(i)) begin
        in_ready[i] = load_en && grant_vld;
        grant_data  = in_data[i*W +: W];
`ifdef MUX_ARB_N_LOCK_EN
        grant_last  = in_last[i];
`endif
      end
    end
  end

  assign in_xfer = |(in_valid & in_ready);
  assign ptr_inc = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);

  // Next state of the output register, pointer, lock and handshake counter.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (out_hs) cnt_d = cnt_q + 16'd1;
    if (in_xfer) begin
      valid_d = 1'b1;
      data_d  = grant_data;
      ch_d    = grant_idx;
    end else if (out_hs) begin
      valid_d = 1'b0;
    end
    if (in_xfer && mode) ptr_d = ptr_inc;
`ifdef MUX_ARB_N_LOCK_EN
    lock_d = lock_q;
    last_d = last_q;
    if (in_xfer) last_d = grant_last;
    if (!mode) begin
      lock_d = 1'b0;
    end else if (in_xfer) begin
      if (grant_last) begin
        lock_d = 1'b0;
      end else begin
        // Park the pointer on the locked channel; the closing beat advances it.
        lock_d = 1'b1;
        ptr_d  = grant_idx;
      end
    end
`endif
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    if (rst) begin
      // NOTE: the data register is reset too, because out_data must read 0 in reset.
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
`ifdef MUX_ARB_N_LOCK_EN
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
`ifdef MUX_ARB_N_LOCK_EN
      lock_q  <= lock_d;
      last_q  <= last_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign xfer_cnt  = cnt_q;
`ifdef MUX_ARB_N_LOCK_EN
  assign out_last  = last_q;
`endif

endmodule

// File: tb/tb_mux_arb_n.sv
// tb_mux_arb_n: self-checking bench for mux_arb_n with a transaction-level
// reference model (pointer, output slot, handshake count) kept in the bench.
module tb_mux_arb_n;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_ready;
  logic [15:0]    xfer_cnt;
`ifdef MUX_ARB_N_LOCK_EN
  logic [N-1:0]   in_last;
  logic           out_last;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int           m_ptr;
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_ch;
  int           m_cnt;

  mux_arb_n #(.W(W), .N(N), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
`ifdef MUX_ARB_N_LOCK_EN
    ,
    .in_last   (in_last),
    .out_last  (out_last)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = '0; m_ch = 0; m_cnt = 0;
  endtask

  function automatic void m_grant(output bit v, output int g);
    v = 0; g = 0;
    if (!mode) begin
      if (int'(sel) < N) begin v = 1; g = int'(sel); end
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!v && in_valid[c]) begin v = 1; g = c; end
      end
    end
  endfunction

  function automatic logic [N-1:0] exp_ready();
    bit v; int g;
    m_grant(v, g);
    if (v && (!m_valid || out_ready)) return N'(1 << g);
    return '0;
  endfunction

  // Advance the model by one clock using the inputs as they stand before the edge.
  task automatic m_update();
    bit v; int g; bit load, xfer, hs;
    if (rst) begin model_reset(); return; end
    m_grant(v, g);
    load = !m_valid || out_ready;
    xfer = load && v && in_valid[g];
    hs   = m_valid && out_ready;
    if (hs) m_cnt = (m_cnt + 1) % 65536;
    if (xfer) begin
      m_valid = 1; m_data = in_data[g*W +: W]; m_ch = g;
      if (mode) m_ptr = (g + 1) % N;
    end else if (hs) begin
      m_valid = 0;
    end
  endtask

  task automatic tick();
    m_update();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; mode = 0; sel = '0; in_valid = '0; in_data = '0; out_ready = 0;
`ifdef MUX_ARB_N_LOCK_EN
    in_last = '1;
`endif
    model_reset();
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_data got %h want 0", out_data); end
    n_cmp++; if (out_ch !== '0) begin n_bad++; $display("FAIL reset_ch got %0d want 0", out_ch); end
    n_cmp++; if (xfer_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", xfer_cnt); end
    n_cmp++; if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL reset_ready got %b want 0001", in_ready); end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_fixed_select();
    mode = 0; out_ready = 1; in_valid = '1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA0 + i;
    for (int s = 0; s < N; s++) begin
      sel = SW'(s);
      #1;
      n_cmp++; if (in_ready !== N'(1 << s)) begin n_bad++; $display("FAIL fixed_ready sel=%0d got %b want %b", s, in_ready, N'(1 << s)); end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'hA0 + s || out_ch !== SW'(s)) begin
        n_bad++;
        $display("FAIL fixed_beat sel=%0d got v=%0b d=%h ch=%0d want v=1 d=%h ch=%0d",
                 s, out_valid, out_data, out_ch, 32'hA0 + s, s);
      end
    end
  endtask

  task automatic test_rr_all_valid();
    mode = 1; out_ready = 1; in_valid = '1;
    for (int k = 0; k < 2 * N; k++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_ch !== SW'(k % N) || out_data !== 32'hA0 + (k % N)) begin
        n_bad++;
        $display("FAIL rr_seq beat=%0d got v=%0b ch=%0d d=%h want v=1 ch=%0d d=%h",
                 k, out_valid, out_ch, out_data, k % N, 32'hA0 + (k % N));
      end
    end
    n_cmp++; if (xfer_cnt !== 16'(m_cnt)) begin n_bad++; $display("FAIL rr_cnt got %0d want %0d", xfer_cnt, m_cnt); end
  endtask

  task automatic test_rr_sparse();
    int exp_seq [3] = '{3, 1, 3};
    mode = 1; out_ready = 1;
    in_valid = 4'b0010;  // one beat from channel 1 leaves the pointer at 2
    tick();
    n_cmp++; if (out_ch !== 2'd1) begin n_bad++; $display("FAIL sparse_setup got ch=%0d want 1", out_ch); end
    in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (out_ch !== SW'(exp_seq[k])) begin
        n_bad++; $display("FAIL sparse_grant step=%0d got ch=%0d want %0d", k, out_ch, exp_seq[k]);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0]  d0;
    logic [SW-1:0] c0;
    logic [15:0]   n0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_pre got v=%0b want 1", out_valid); end
    out_ready = 0;
    d0 = out_data; c0 = out_ch; n0 = xfer_cnt;
    for (int k = 0; k < 5; k++) begin
      in_valid = N'($urandom());
      mode     = 1'($urandom());
      sel      = SW'($urandom());
      #1;
      n_cmp++; if (in_ready !== '0) begin n_bad++; $display("FAIL stall_ready cyc=%0d got %b want 0000", k, in_ready); end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== d0 || out_ch !== c0 || xfer_cnt !== n0) begin
        n_bad++;
        $display("FAIL stall_hold cyc=%0d got v=%0b d=%h ch=%0d cnt=%0d want v=1 d=%h ch=%0d cnt=%0d",
                 k, out_valid, out_data, out_ch, xfer_cnt, d0, c0, n0);
      end
    end
    out_ready = 1;
  endtask

  task automatic test_random();
    logic [W+SW+16:0] got, exp;
    logic [N-1:0]     er;
    for (int k = 0; k < 300; k++) begin
      mode      = ($urandom_range(0, 3) != 0);
      sel       = SW'($urandom());
      in_valid  = N'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom();
      #1;
      er = exp_ready();
      n_cmp++;
      if (in_ready !== er || $countones(in_ready) > 1) begin
        n_bad++; $display("FAIL rand_ready cyc=%0d got %b want %b", k, in_ready, er);
      end
      tick();
      got = {out_valid, out_data, out_ch, xfer_cnt};
      exp = {m_valid, m_data, SW'(m_ch), 16'(m_cnt)};
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL rand_out cyc=%0d got {v,d,ch,cnt}=%h want %h", k, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    mode = 1; out_ready = 1; in_valid = 4'b0010;
    tick();                        // pointer moves off channel 0
    out_ready = 0; in_valid = '0;
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL areset_pre got v=%0b want 1", out_valid); end
    #3 rst = 1;                    // between clock edges
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_ch !== '0 || xfer_cnt !== 16'd0 || out_data !== '0) begin
      n_bad++;
      $display("FAIL areset_now got v=%0b ch=%0d cnt=%0d d=%h want all 0", out_valid, out_ch, xfer_cnt, out_data);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    in_valid = '1; out_ready = 1;
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL areset_ready got %b want 0001", in_ready); end
    tick();
    n_cmp++; if (out_ch !== 2'd0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL areset_restart got ch=%0d v=%0b want ch=0 v=1", out_ch, out_valid); end
  endtask

`ifdef MUX_ARB_N_LOCK_EN
  task automatic test_lock();
    int  exp_ch [4] = '{0, 0, 0, 1};
    bit  lasts  [4] = '{0, 0, 1, 1};
    rst = 1; #2; rst = 0;
    model_reset();
    @(posedge clk); #1;
    mode = 1; out_ready = 1; in_valid = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      in_last = {N{1'b1}};
      in_last[0] = lasts[k];
      @(posedge clk); #1;
      n_cmp++;
      if (out_ch !== SW'(exp_ch[k])) begin
        n_bad++; $display("FAIL lock_seq beat=%0d got ch=%0d want %0d", k, out_ch, exp_ch[k]);
      end
    end
    in_last = '1;
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fixed_select();
    test_rr_all_valid();
    test_rr_sparse();
    test_stall();
    test_random();
    test_async_reset();
`ifdef MUX_ARB_N_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
